// File: rtl/addsub_pkg.sv
// Shared definitions for the sequential adder-subtractor.
//   MODE_*  : operation codes carried on the 2-bit mode input.
//             mode[0] selects subtraction, mode[1] selects the accumulator as A.
//   state_t : controller state encoding, also exported on the debug port.
package addsub_pkg;

  localparam logic [1:0] MODE_ADD     = 2'b00;
  localparam logic [1:0] MODE_SUB     = 2'b01;
  localparam logic [1:0] MODE_ACC_ADD = 2'b10;
  localparam logic [1:0] MODE_ACC_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder used once per clock by the sequential
// adder-subtractor.
//   a, b     : digit operands
//   cin      : carry into bit 0
//   sum      : digit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (overflow detection on the last digit)
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_adder_subtractor.sv
// Multi-cycle two's-complement adder-subtractor with a running accumulator.
// One DIGIT-bit slice is added per clock, least-significant digit first.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, mode, a, b  : operation request; sampled together in IDLE only
//   acc_clr            : clear accumulator; honoured in IDLE only, wins over
//                        the accumulator value when paired with start
//   busy               : digits are being processed
//   done               : one-cycle pulse, result/flags just updated
//   result             : sum/difference, held until the next completion
//   carry              : carry out of MSB (subtract: 1 = no borrow)
//   overflow           : signed overflow (carry into MSB ^ carry out of MSB)
//   zero               : result == 0
//   dbg_state          : current controller state
//
// Handshake: start is a request that is accepted only on an edge where the
// controller is IDLE; there is no ready signal and requests seen while busy
// or done are dropped, not queued. busy rises on the accepting edge and stays
// high for N cycles; done then pulses for exactly one cycle with busy low.
// After the done cycle the controller returns to IDLE, so the next request
// can be accepted N+2 edges after the previous one.
module seq_adder_subtractor
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("seq_adder_subtractor: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             carry_q;

  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic [WIDTH-1:0] res_next;

  assign dbg_state = state;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a        (op_a[DIGIT-1:0]),
    .b        (op_b[DIGIT-1:0]),
    .cin      (carry_q),
    .sum      (d_sum),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  // New digits enter at the top; after N shifts digit 0 sits at bit 0.
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      res_sh   <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (start) begin
            // mode[1] picks the accumulator as A; a same-cycle clear wins.
            op_a    <= mode[1] ? (acc_clr ? '0 : acc) : a;
            // Subtraction is A + ~B + 1: invert B and preset the carry.
            op_b    <= b ^ {WIDTH{mode[0]}};
            carry_q <= mode[0];
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          op_a    <= op_a >> DIGIT;
          op_b    <= op_b >> DIGIT;
          res_sh  <= res_next;
          carry_q <= d_cout;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= res_next;
            carry    <= d_cout;
            overflow <= d_cout ^ d_cmsb;
            zero     <= (res_next == '0);
            acc      <= res_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder_subtractor.sv
module tb_seq_adder_subtractor;

  localparam int W = 16;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit / 4-bit-digit instance
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          acc_clr = 1'b0;
  logic          busy, done, carry, overflow, zero;
  logic [W-1:0]  result;
  logic [1:0]    dbg_state;

  // 8-bit / single-digit instance
  logic          s8_start = 1'b0;
  logic [1:0]    s8_mode = 2'b00;
  logic [7:0]    s8_a = '0;
  logic [7:0]    s8_b = '0;
  logic          s8_acc_clr = 1'b0;
  logic          s8_busy, s8_done, s8_carry, s8_overflow, s8_zero;
  logic [7:0]    s8_result;
  logic [1:0]    s8_dbg_state;

  seq_adder_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .a(a), .b(b),
    .acc_clr(acc_clr), .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .dbg_state(dbg_state)
  );

  seq_adder_subtractor #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .mode(s8_mode), .a(s8_a),
    .b(s8_b), .acc_clr(s8_acc_clr), .busy(s8_busy), .done(s8_done),
    .result(s8_result), .carry(s8_carry), .overflow(s8_overflow),
    .zero(s8_zero), .dbg_state(s8_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] acc_m = '0;

  // Reference: plain integer arithmetic on the operation's meaning.
  function automatic void model(input logic [1:0] m, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic clr,
                                output logic [W-1:0] r, output logic c,
                                output logic ov, output logic z);
    logic [W-1:0] opa;
    logic [W:0]   s;
    if (clr) acc_m = '0;
    opa = m[1] ? acc_m : av;
    if (!m[0]) begin
      s  = {1'b0, opa} + {1'b0, bv};
      r  = s[W-1:0];
      c  = s[W];
      ov = (opa[W-1] == bv[W-1]) && (r[W-1] != opa[W-1]);
    end else begin
      r  = opa - bv;
      c  = (opa >= bv);
      ov = (opa[W-1] != bv[W-1]) && (r[W-1] != opa[W-1]);
    end
    z = (r == '0);
    acc_m = r;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation, waits for done (bounded), then one more edge so the
  // controller is back in IDLE. lat = edges from accept to done rising.
  task automatic do_op(input logic [1:0] m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic clr,
                       input logic clr_busy, output int lat,
                       output logic both_hi);
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv; acc_clr = clr;
    @(posedge clk); #1;
    start = 1'b0; acc_clr = 1'b0;
    mode = 2'($urandom); a = W'($urandom); b = W'($urandom);
    lat = 0; both_hi = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      acc_clr = clr_busy;
      @(posedge clk); #1;
      lat++;
      if (busy && done) both_hi = 1'b1;
    end
    acc_clr = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({busy, done, carry, overflow, zero} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {busy, done, carry, overflow, zero}); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL reset_result: got %h want 0000", result); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    total_cnt++; if (s8_result !== 8'h00 || s8_done !== 1'b0)
      $display("FAIL reset_s8: got %h/%b want 00/0", s8_result, s8_done); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    acc_m = '0;
  endtask

  task automatic test_directed();
    logic [1:0]   tm[5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [W-1:0] ta[5] = '{16'h1234, 16'h0005, 16'h0007, 16'h7FFF, 16'hFFFF};
    logic [W-1:0] tb[5] = '{16'h0FFF, 16'h0007, 16'h0005, 16'h0001, 16'h0001};
    logic [W-1:0] tr[5] = '{16'h2233, 16'hFFFE, 16'h0002, 16'h8000, 16'h0000};
    logic [W-1:0] er; logic ec, eo, ez; int lat; logic bh;
    for (int i = 0; i < 5; i++) begin
      model(tm[i], ta[i], tb[i], 1'b0, er, ec, eo, ez);
      do_op(tm[i], ta[i], tb[i], 1'b0, 1'b0, lat, bh);
      total_cnt++; if (result !== er) $display("FAIL dir%0d_result: got %h want %h", i, result, er); else pass_cnt++;
      total_cnt++; if (result !== tr[i]) $display("FAIL dir%0d_table: got %h want %h", i, result, tr[i]); else pass_cnt++;
      total_cnt++; if ({carry, overflow, zero} !== {ec, eo, ez})
        $display("FAIL dir%0d_flags: got %b want %b", i, {carry, overflow, zero}, {ec, eo, ez}); else pass_cnt++;
      total_cnt++; if (lat != N) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, N); else pass_cnt++;
      total_cnt++; if (bh !== 1'b0) $display("FAIL dir%0d_busy_done: got %b want 0", i, bh); else pass_cnt++;
    end
  endtask

  task automatic test_accumulate();
    logic [1:0]   tm[5] = '{2'b10, 2'b10, 2'b11, 2'b10, 2'b10};
    logic [W-1:0] tb[5] = '{16'h0010, 16'h0010, 16'h0020, 16'h0055, 16'h0001};
    logic         tc[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         tbz[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] tr[5] = '{16'h0010, 16'h0020, 16'h0000, 16'h0055, 16'h0056};
    logic [W-1:0] er; logic ec, eo, ez; int lat; logic bh;
    for (int i = 0; i < 5; i++) begin
      model(tm[i], W'($urandom), tb[i], tc[i], er, ec, eo, ez);
      do_op(tm[i], 16'hA5A5, tb[i], tc[i], tbz[i], lat, bh);
      total_cnt++; if (result !== er) $display("FAIL acc%0d_result: got %h want %h", i, result, er); else pass_cnt++;
      total_cnt++; if (result !== tr[i]) $display("FAIL acc%0d_table: got %h want %h", i, result, tr[i]); else pass_cnt++;
      total_cnt++; if ({carry, overflow, zero} !== {ec, eo, ez})
        $display("FAIL acc%0d_flags: got %b want %b", i, {carry, overflow, zero}, {ec, eo, ez}); else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [1:0] m; logic [W-1:0] av, bv, er, got; logic clr, ec, eo, ez; int lat; logic bh;
    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom); av = W'($urandom); bv = W'($urandom);
      clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) bv = av;
      model(m, av, bv, clr, er, ec, eo, ez);
      exp_q.push_back(er);
      do_op(m, av, bv, clr, 1'b0, lat, bh);
      got = exp_q.pop_front();
      total_cnt++; if (result !== got) $display("FAIL rnd%0d_result: got %h want %h", i, result, got); else pass_cnt++;
      total_cnt++; if ({carry, overflow, zero} !== {ec, eo, ez})
        $display("FAIL rnd%0d_flags: got %b want %b", i, {carry, overflow, zero}, {ec, eo, ez}); else pass_cnt++;
      total_cnt++; if (lat != N || bh !== 1'b0)
        $display("FAIL rnd%0d_timing: got lat %0d/%b want %0d/0", i, lat, bh, N); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] er; logic ec, eo, ez; int ndone; logic bh;
    for (int k = 0; k < 3; k++) model(2'b00, 16'h1111, 16'h2222, 1'b0, er, ec, eo, ez);
    ndone = 0; bh = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 2'b00; a = 16'h1111; b = 16'h2222;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy && done) bh = 1'b1;
    end
    start = 1'b0;
    repeat (2 * (N + 2)) @(posedge clk);
    #1;
    total_cnt++; if (ndone != 3) $display("FAIL b2b_done_count: got %0d want 3", ndone); else pass_cnt++;
    total_cnt++; if (bh !== 1'b0) $display("FAIL b2b_busy_done: got %b want 0", bh); else pass_cnt++;
    total_cnt++; if (result !== er) $display("FAIL b2b_result: got %h want %h", result, er); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] er; logic ec, eo, ez; int lat; logic bh;
    @(negedge clk);
    start = 1'b1; mode = 2'b01; a = 16'h0005; b = 16'h0007;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #2; rst_n = 1'b0;
    #1;
    total_cnt++; if ({busy, done, carry, overflow, zero} !== 5'b0)
      $display("FAIL rstmid_flags: got %b want 00000", {busy, done, carry, overflow, zero}); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL rstmid_result: got %h want 0000", result); else pass_cnt++;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL rstmid_state: got %0d want 0", dbg_state); else pass_cnt++;
    acc_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model(2'b00, 16'h0001, 16'h0001, 1'b0, er, ec, eo, ez);
    do_op(2'b00, 16'h0001, 16'h0001, 1'b0, 1'b0, lat, bh);
    total_cnt++; if (result !== 16'h0002 || result !== er)
      $display("FAIL rstmid_after: got %h want %h", result, er); else pass_cnt++;
    // accumulator was reloaded by the 1+1 completion, not left stale
    model(2'b10, 16'h0000, 16'h0005, 1'b0, er, ec, eo, ez);
    do_op(2'b10, 16'h0000, 16'h0005, 1'b0, 1'b0, lat, bh);
    total_cnt++; if (result !== er) $display("FAIL rstmid_acc: got %h want %h", result, er); else pass_cnt++;
  endtask

  task automatic test_narrow();
    int lat;
    @(negedge clk);
    s8_start = 1'b1; s8_mode = 2'b00; s8_a = 8'h80; s8_b = 8'h80;
    @(posedge clk); #1;
    s8_start = 1'b0; s8_a = 8'h00; s8_b = 8'h00;
    lat = 0;
    while (s8_done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    total_cnt++; if (lat != 1) $display("FAIL s8_latency: got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (s8_result !== 8'h00) $display("FAIL s8_result: got %h want 00", s8_result); else pass_cnt++;
    total_cnt++; if ({s8_carry, s8_overflow, s8_zero} !== 3'b111)
      $display("FAIL s8_flags: got %b want 111", {s8_carry, s8_overflow, s8_zero}); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_directed();
    test_accumulate();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_adder_subtractor.md
# seq_adder_subtractor

Parametrised, multi-cycle two's-complement adder-subtractor with an internal accumulator and a start/busy/done handshake. It processes a WIDTH-bit operation DIGIT bits per clock, least-significant digit first, and carries the digit carry in a register. It reports carry/borrow, signed overflow and zero flags. It sits in the arithmetic datapath as the wide, area-lean successor to the team's fixed 4-bit combinational adder-subtractor, and it adds running-sum (accumulate) operation.

## Interface
- WIDTH, 16: operand/result width in bits. Must be a multiple of DIGIT.
- DIGIT, 4: bits processed per clock. N = WIDTH/DIGIT is the number of digit cycles.
- clk  input  1  single clock. All state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request an operation. Sampled only in IDLE.
- mode  input  2  operation select, sampled with start:
  - 00 ADD: a+b
  - 01 SUB: a−b
  - 10 ACC_ADD: acc+b
  - 11 ACC_SUB: acc−b
- a  input  WIDTH  operand A. Sampled with start; ignored in ACC modes.
- b  input  WIDTH  operand B. Sampled with start.
- acc_clr  input  1  clear the accumulator. Honoured only in IDLE.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse: result and flags have just been updated.
- result  output  WIDTH  sum/difference. Held until the next completion.
- carry  output  1  carry-out of the MSB. For SUB modes, 1 = no borrow.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  result == 0.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - With start=1: latch operand A (a, or acc in ACC modes), latch b XOR {WIDTH{mode[0]}}, preset carry register = mode[0], clear digit index, then go to BUSY.
  - With start=0: stay in IDLE.
- **BUSY:** each cycle adds digit k of A, modified B and the carry register in sub-module digit_adder. Store the sum digit, update the carry register, k++. After digit N−1 is processed, go to DONE.
- **DONE:** result, carry, overflow and zero are visible; done=1. The accumulator is loaded with result on every completion, in every mode. Next state is IDLE unconditionally.
- **acc_clr:**
  - In IDLE: clears acc to 0 on the same edge.
  - With start in the same cycle: clear has priority, so an ACC-mode operation uses A = 0.
  - In BUSY or DONE: ignored.
- **start** in BUSY or DONE is ignored and is not queued.
- **Arithmetic:** modulo 2^WIDTH; no saturation. overflow uses the carry into and out of the MSB, both produced during the last digit cycle.
- **Reset (asynchronous, any state, including mid-operation):**
  - state = IDLE
  - busy, done, carry, overflow, zero = 0; result = 0; acc = 0
  - any partial result is discarded.

## Timing
- start sampled high at edge t: busy=1 for cycles t+1 through t+N, digits 0 through N−1.
- done=1 and new result/flags in cycle t+N+1. Latency is N+1 clocks.
- The earliest next start is accepted at edge t+N+2, giving an initiation interval of N+2.
- busy and done are never high together. Both are registered outputs.
- result and flags change only at the edge that enters DONE, or at reset.
- With DIGIT=WIDTH, N=1: busy lasts 1 cycle and done follows at t+2.

## Structure
- Package addsub_pkg holds:
  - mode constants MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC_ADD=2'b10, MODE_ACC_SUB=2'b11
  - state encoding IDLE/BUSY/DONE
- Sub-module digit_adder, parameter DIGIT: a DIGIT-bit ripple adder with cin. Outputs are sum, cout, and c_msb_in (carry into its top bit, used for overflow).
- Top level holds:
  - FSM
  - operand registers, shifted right by DIGIT each BUSY cycle
  - result shift register
  - digit counter ($clog2(N+1) bits)
  - carry register
  - accumulator
- Elaboration check: WIDTH % DIGIT == 0.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
- ADD 0x1234+0x0FFF: done exactly 5 cycles after start; result 0x2233, carry 0, overflow 0, zero 0.
- SUB 0x0005−0x0007: result 0xFFFE, carry 0 (borrow), overflow 0.
- SUB 0x0007−0x0005: result 0x0002, carry 1.
- Flag boundaries:
  - ADD 0x7FFF+0x0001: result 0x8000, overflow 1, carry 0.
  - ADD 0xFFFF+0x0001: result 0x0000, zero 1, carry 1, overflow 0.
- Accumulate sequence:
  - start+acc_clr with ACC_ADD, b=0x0010: result 0x0010.
  - ACC_ADD, b=0x0010: result 0x0020.
  - ACC_SUB, b=0x0020: result 0x0000, zero 1, carry 1.
  - acc_clr pulsed while busy has no effect.
- Handshake and reset:
  - start held high through BUSY: exactly one done per N+2 cycles.
  - rst_n low in the 2nd busy cycle: all outputs 0 immediately.
  - After release, ADD 0x0001+0x0001 gives 0x0002.
- Config WIDTH=8, DIGIT=8: ADD 0x80+0x80 → result 0x00, carry 1, overflow 1, zero 1; done 2 cycles after start.
